// File: rtl/led_adc_sequencer_pkg.sv
// Shared types and defaults for the LED/ADC sequencer: state encoding,
// default timing, and small state-class helpers used by the FSM and output decode.
package led_adc_sequencer_pkg;

    localparam int DEF_HALF_PERIOD_CYC = 50000;
    localparam int DEF_SETTLE_CYC      = 5000;
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_ADC_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RED_SETTLE = 3'd1,
        ST_RED_CONV   = 3'd2,
        ST_RED_HOLD   = 3'd3,
        ST_IR_SETTLE  = 3'd4,
        ST_IR_CONV    = 3'd5,
        ST_IR_HOLD    = 3'd6
    } state_t;

    function automatic logic is_red_phase(input state_t s);
        return (s == ST_RED_SETTLE) || (s == ST_RED_CONV) || (s == ST_RED_HOLD);
    endfunction

    function automatic logic is_ir_phase(input state_t s);
        return (s == ST_IR_SETTLE) || (s == ST_IR_CONV) || (s == ST_IR_HOLD);
    endfunction

    function automatic logic is_settle(input state_t s);
        return (s == ST_RED_SETTLE) || (s == ST_IR_SETTLE);
    endfunction

    function automatic logic is_conv(input state_t s);
        return (s == ST_RED_CONV) || (s == ST_IR_CONV);
    endfunction

endpackage

// File: rtl/led_adc_sequencer_phase_timer.sv
// Per-phase cycle counter: runs 0..HALF_PERIOD_CYC-1 and wraps, flags the
// ADC trigger count and the last count of the phase.
module led_phase_timer #(
    parameter int CNT_W           = 16,
    parameter int HALF_PERIOD_CYC = 50000,
    parameter int SETTLE_CYC      = 5000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_settle,
    output logic             o_at_end
);

    localparam logic [CNT_W-1:0] LP_END    = CNT_W'(HALF_PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SETTLE_CYC);

    logic [CNT_W-1:0] r_count;
    logic             w_at_end;

    assign w_at_end = (r_count == LP_END);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || w_at_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count     = r_count;
    assign o_at_settle = (r_count == LP_SETTLE);
    assign o_at_end    = w_at_end;

endmodule

// File: rtl/led_adc_sequencer.sv
// Pulse-oximeter front end: alternates RED/IR LED phases, fires one ADC
// conversion per phase and demultiplexes results into per-LED sample registers.
module led_adc_sequencer
    import led_adc_sequencer_pkg::*;
#(
    parameter int HALF_PERIOD_CYC = DEF_HALF_PERIOD_CYC,
    parameter int SETTLE_CYC      = DEF_SETTLE_CYC,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int ADC_W           = DEF_ADC_W
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             En,
    output logic             ADC_Start,
    input  logic             ADC_Done,
    input  logic [ADC_W-1:0] ADC_Data,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic             RED_Valid,
    output logic             IR_Valid,
    output logic             ADC_Timeout,
    output state_t           o_dbg_state
);

    state_t           r_state;
    state_t           w_next;

    logic [CNT_W-1:0] w_count;
    logic             w_at_settle;
    logic             w_at_end;
    logic             w_clear;

    logic             w_led_red;
    logic             w_led_ir;
    logic             w_adc_start;
    logic             w_cap_red;
    logic             w_cap_ir;
    logic             w_timeout;

    logic [ADC_W-1:0] r_red_val;
    logic [ADC_W-1:0] r_ir_val;
    logic             r_red_valid;
    logic             r_ir_valid;
    logic             r_timeout;

    // Counter is held at 0 while idle so the first active cycle is count 0.
    assign w_clear = (r_state == ST_IDLE) || !En;

    led_phase_timer #(
        .CNT_W           (CNT_W),
        .HALF_PERIOD_CYC (HALF_PERIOD_CYC),
        .SETTLE_CYC      (SETTLE_CYC)
    ) u_timer (
        .i_clk       (CLK),
        .i_rst       (rst),
        .i_clear     (w_clear),
        .o_count     (w_count),
        .o_at_settle (w_at_settle),
        .o_at_end    (w_at_end)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase end has priority over conversion progress: the LEDs never stretch.
    always_comb begin
        w_next = r_state;
        if (!En) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       w_next = ST_RED_SETTLE;
                ST_RED_SETTLE: begin
                    if (w_at_end)         w_next = ST_IR_SETTLE;
                    else if (w_at_settle) w_next = ST_RED_CONV;
                end
                ST_RED_CONV: begin
                    if (w_at_end)      w_next = ST_IR_SETTLE;
                    else if (ADC_Done) w_next = ST_RED_HOLD;
                end
                ST_RED_HOLD: begin
                    if (w_at_end) w_next = ST_IR_SETTLE;
                end
                ST_IR_SETTLE: begin
                    if (w_at_end)         w_next = ST_RED_SETTLE;
                    else if (w_at_settle) w_next = ST_IR_CONV;
                end
                ST_IR_CONV: begin
                    if (w_at_end)      w_next = ST_RED_SETTLE;
                    else if (ADC_Done) w_next = ST_IR_HOLD;
                end
                ST_IR_HOLD: begin
                    if (w_at_end) w_next = ST_RED_SETTLE;
                end
                default:       w_next = ST_IDLE;
            endcase
        end
    end

    // ADC handshake: ADC_Start is a one-cycle request with no backpressure;
    // ADC_Done is a one-cycle pulse qualifying ADC_Data in the same cycle.
    always_comb begin
        w_led_red   = 1'b0;
        w_led_ir    = 1'b0;
        w_adc_start = 1'b0;
        w_cap_red   = 1'b0;
        w_cap_ir    = 1'b0;
        w_timeout   = 1'b0;
        if (w_count != '0) begin
            w_led_red = is_red_phase(r_state);
            w_led_ir  = is_ir_phase(r_state);
        end
        if (En) begin
            w_adc_start = is_settle(r_state) && w_at_settle;
            w_cap_red   = (r_state == ST_RED_CONV) && ADC_Done;
            w_cap_ir    = (r_state == ST_IR_CONV) && ADC_Done;
            w_timeout   = is_conv(r_state) && w_at_end && !ADC_Done;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_red_val   <= '0;
            r_ir_val    <= '0;
            r_red_valid <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_red_valid <= w_cap_red;
            r_ir_valid  <= w_cap_ir;
            r_timeout   <= w_timeout;
            if (w_cap_red) r_red_val <= ADC_Data;
            if (w_cap_ir)  r_ir_val  <= ADC_Data;
        end
    end

    assign ADC_Start     = w_adc_start;
    assign LED_RED       = w_led_red;
    assign LED_IR        = w_led_ir;
    assign RED_ADC_Value = r_red_val;
    assign IR_ADC_Value  = r_ir_val;
    assign RED_Valid     = r_red_valid;
    assign IR_Valid      = r_ir_valid;
    assign ADC_Timeout   = r_timeout;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Bench for led_adc_sequencer with short phases (20 cycles, trigger at count 4)
// and a scripted ADC responder feeding an expected-event queue.
module tb_led_adc_sequencer;

    localparam int LP_HALF = 20;
    localparam int LP_SET  = 4;
    localparam int LP_ADCW = 8;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_AT_END  = 1;
    localparam int MODE_SILENT  = 2;
    localparam int MODE_IGNORED = 3;

    logic               CLK;
    logic               rst;
    logic               En;
    logic               ADC_Start;
    logic               ADC_Done;
    logic [LP_ADCW-1:0] ADC_Data;
    logic               LED_RED;
    logic               LED_IR;
    logic [LP_ADCW-1:0] RED_ADC_Value;
    logic [LP_ADCW-1:0] IR_ADC_Value;
    logic               RED_Valid;
    logic               IR_Valid;
    logic               ADC_Timeout;
    logic [2:0]         dbg_state;

    int n_vec;
    int n_err;
    int cyc;

    logic               m_act;
    logic               m_red;
    int                 m_cnt;

    int                 mode_red;
    int                 mode_ir;
    logic [LP_ADCW-1:0] data_red;
    logic [LP_ADCW-1:0] data_ir;

    // entry: {cycle[31:0], kind[1:0] (0 red, 1 ir, 2 timeout), data[7:0]}
    logic [41:0] exp_q[$];

    led_adc_sequencer #(
        .HALF_PERIOD_CYC (LP_HALF),
        .SETTLE_CYC      (LP_SET),
        .CNT_W           (16),
        .ADC_W           (LP_ADCW)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .En            (En),
        .ADC_Start     (ADC_Start),
        .ADC_Done      (ADC_Done),
        .ADC_Data      (ADC_Data),
        .LED_RED       (LED_RED),
        .LED_IR        (LED_IR),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .RED_Valid     (RED_Valid),
        .IR_Valid      (IR_Valid),
        .ADC_Timeout   (ADC_Timeout),
        .o_dbg_state   (dbg_state)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] kind_bits(input logic [1:0] k);
        logic [2:0] one;
        one = 3'b001;
        return one << k;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // reference phase model, advanced on the same edge as the DUT
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0;
            m_red <= 1'b1;
            m_cnt <= 0;
        end else if (!En) begin
            m_act <= 1'b0;
            m_red <= 1'b1;
            m_cnt <= 0;
        end else if (!m_act) begin
            m_act <= 1'b1;
            m_red <= 1'b1;
            m_cnt <= 0;
        end else if (m_cnt == LP_HALF - 1) begin
            m_cnt <= 0;
            m_red <= ~m_red;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // LED / trigger checks every cycle
    always @(negedge CLK) begin
        chk("led_red",   {31'b0, LED_RED},   {31'b0, m_act && m_red && (m_cnt != 0)});
        chk("led_ir",    {31'b0, LED_IR},    {31'b0, m_act && !m_red && (m_cnt != 0)});
        chk("led_excl",  {31'b0, LED_RED & LED_IR}, 32'd0);
        chk("adc_start", {31'b0, ADC_Start}, {31'b0, m_act && (m_cnt == LP_SET)});
    end

    // ADC responder: reacts to each ADC_Start according to the phase's mode
    initial begin : responder
        logic               red;
        int                 mode;
        int                 dly;
        int                 s;
        logic [LP_ADCW-1:0] d;
        ADC_Done = 1'b0;
        ADC_Data = '0;
        forever begin
            @(negedge CLK);
            if (ADC_Start === 1'b1) begin
                red  = m_red;
                mode = red ? mode_red : mode_ir;
                d    = red ? data_red : data_ir;
                s    = cyc;
                dly  = 0;
                case (mode)
                    MODE_NORMAL: begin
                        dly = 3;
                        exp_q.push_back({32'(s + dly + 1), red ? 2'd0 : 2'd1, d});
                    end
                    MODE_AT_END: begin
                        dly = LP_HALF - 1 - LP_SET;
                        exp_q.push_back({32'(s + dly + 1), red ? 2'd0 : 2'd1, d});
                    end
                    MODE_SILENT: begin
                        exp_q.push_back({32'(s + LP_HALF - LP_SET), 2'd2, 8'h00});
                    end
                    default: dly = 3;
                endcase
                if (dly != 0) begin
                    repeat (dly) @(posedge CLK);
                    #1;
                    ADC_Done = 1'b1;
                    ADC_Data = d;
                    @(posedge CLK);
                    #1;
                    ADC_Done = 1'b0;
                    ADC_Data = LP_ADCW'($urandom_range(0, 255));
                end
            end
        end
    end

    // scoreboard: every Valid/Timeout strobe must match the queue head
    always @(negedge CLK) begin : scoreboard
        logic [2:0]  ev;
        logic [41:0] e;
        ev = {ADC_Timeout, IR_Valid, RED_Valid};
        if (ev != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'b0, ev}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind",  {29'b0, ev}, {29'b0, kind_bits(e[9:8])});
                chk("event_cycle", cyc, e[41:10]);
                if (e[9:8] == 2'd0) chk("red_value", {24'b0, RED_ADC_Value}, {24'b0, e[7:0]});
                if (e[9:8] == 2'd1) chk("ir_value",  {24'b0, IR_ADC_Value},  {24'b0, e[7:0]});
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0][41:10]) < cyc) begin
            e = exp_q.pop_front();
            chk("missing_event", {29'b0, ev}, {29'b0, kind_bits(e[9:8])});
        end
    end

    // driver tasks
    task automatic wait_phase(input logic red, input int cnt);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(m_act && (m_red == red) && (m_cnt == cnt)) && n < 200);
        chk("wait_phase", {31'b0, n < 200}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_led_red"},   {31'b0, LED_RED},     32'd0);
        chk({tag, "_led_ir"},    {31'b0, LED_IR},      32'd0);
        chk({tag, "_start"},     {31'b0, ADC_Start},   32'd0);
        chk({tag, "_red_val"},   {24'b0, RED_ADC_Value}, 32'd0);
        chk({tag, "_ir_val"},    {24'b0, IR_ADC_Value},  32'd0);
        chk({tag, "_red_vld"},   {31'b0, RED_Valid},   32'd0);
        chk({tag, "_ir_vld"},    {31'b0, IR_Valid},    32'd0);
        chk({tag, "_timeout"},   {31'b0, ADC_Timeout}, 32'd0);
        chk({tag, "_state"},     {29'b0, dbg_state},   32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        rst      = 1'b1;
        En       = 1'b0;
        mode_red = MODE_NORMAL;
        mode_ir  = MODE_NORMAL;
        data_red = 8'hA5;
        data_ir  = 8'h3C;

        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        @(negedge CLK);
        rst = 1'b0;
        En  = 1'b1;

        // basic alternation and capture of both phases
        wait_phase(1'b0, 10);
        chk("t2_red_val", {24'b0, RED_ADC_Value}, 32'hA5);
        chk("t2_ir_val",  {24'b0, IR_ADC_Value},  32'h3C);

        // IR conversion never answered
        mode_ir  = MODE_SILENT;
        data_red = 8'h11;
        wait_phase(1'b1, 10);
        chk("t3_red_val", {24'b0, RED_ADC_Value}, 32'h11);
        wait_phase(1'b1, 2);
        chk("t3_ir_held", {24'b0, IR_ADC_Value}, 32'h3C);

        // Done on the last count of the IR phase
        mode_ir  = MODE_AT_END;
        data_ir  = 8'h7E;
        data_red = 8'h99;
        wait_phase(1'b1, 2);
        chk("t4_ir_val",  {24'b0, IR_ADC_Value},  32'h7E);
        chk("t4_red_val", {24'b0, RED_ADC_Value}, 32'h99);

        // disable during red conversion, late Done must be ignored
        mode_ir  = MODE_NORMAL;
        data_ir  = 8'hC3;
        mode_red = MODE_IGNORED;
        data_red = 8'hEE;
        wait_phase(1'b1, 5);
        En = 1'b0;
        @(negedge CLK);
        chk("t5_state_idle", {29'b0, dbg_state}, 32'd0);
        repeat (4) @(negedge CLK);
        chk("t5_red_held", {24'b0, RED_ADC_Value}, 32'h99);
        chk("t5_ir_held",  {24'b0, IR_ADC_Value},  32'h7E);
        mode_red = MODE_NORMAL;
        data_red = 8'h42;
        En = 1'b1;
        wait_phase(1'b1, 0);
        chk("t5_restart_state", {29'b0, dbg_state}, 32'd1);
        wait_phase(1'b1, 10);
        chk("t5_red_val", {24'b0, RED_ADC_Value}, 32'h42);

        // asynchronous reset mid red phase, Done arrives while in reset
        mode_red = MODE_IGNORED;
        data_red = 8'hD7;
        wait_phase(1'b1, 6);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        repeat (3) @(negedge CLK);
        check_all_zero("t6_held");
        mode_red = MODE_NORMAL;
        data_red = 8'h5C;
        rst = 1'b0;
        wait_phase(1'b1, 10);
        chk("t6_red_val", {24'b0, RED_ADC_Value}, 32'h5C);
        chk("t6_ir_zero", {24'b0, IR_ADC_Value},  32'h00);

        repeat (3) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
